lbist_ora: RTL and testbench
============================

Name: lbist_ora

Overview:
- Output response analyzer for the LBIST loop. It is the response-side counterpart to the test pattern generator.
- Compacts the CUT's per-cycle responses into a signature using a multiple-input signature register (MISR).
- Counts the applied patterns. After a programmed pattern count, compares the signature against a golden value and reports done/pass to the BIST controller.

Parameters:
- IN_BITS, 4, width of the CUT response bus.
- SIG_BITS, 16, MISR/signature width; must be >= IN_BITS.
- POLY, 16'h002D, MISR feedback polynomial (bit i set = XOR tap into bit i); width SIG_BITS.
- SEED, 0, value loaded into the MISR on start.
- N_PATTERNS, 15, number of valid responses to compact per test; must be >= 1.
- CNT_BITS, 8, pattern counter width; must be large enough to hold N_PATTERNS.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin a new signature run (single-cycle pulse).
- resp_valid  input  1  RESP is a valid CUT response this cycle.
- RESP  input  IN_BITS  CUT response word.
- GOLDEN  input  SIG_BITS  expected signature; must be stable during the CHECK cycle.
- SIGNATURE  output  SIG_BITS  current MISR contents.
- PATTERN_COUNT  output  CNT_BITS  number of responses compacted in the current run.
- busy  output  1  high in RUN and CHECK.
- done  output  1  high in DONE.
- pass  output  1  signature matched GOLDEN; valid only while done=1.

Behaviour:
- Reset (rst=0 at a clk edge) forces the following, regardless of state, including mid-run:
  - state = IDLE
  - SIGNATURE = SEED
  - PATTERN_COUNT = 0
  - busy = 0, done = 0, pass = 0
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE:
  - start=1 → RUN; SIGNATURE <= SEED; PATTERN_COUNT <= 0.
  - resp_valid is ignored.
- RUN:
  - Each edge with resp_valid=1 compacts RESP and increments PATTERN_COUNT.
  - Edges with resp_valid=0 hold all state (stall).
  - When the compaction brings PATTERN_COUNT to N_PATTERNS, the next state is CHECK.
  - start is ignored while in RUN.
- MISR update, one edge per valid response:
  - next = ({SIGNATURE[SIG_BITS-2:0],1'b0}) ^ (SIGNATURE[SIG_BITS-1] ? POLY : 0) ^ zero-extended RESP.
  - RESP bit i XORs into signature bit i.
- CHECK (exactly one cycle):
  - pass <= (SIGNATURE == GOLDEN); done <= 1; next state DONE.
  - resp_valid is ignored.
- DONE:
  - done=1, pass held, SIGNATURE and PATTERN_COUNT frozen; resp_valid is ignored.
  - start=1 → RUN with SEED reload, PATTERN_COUNT cleared, done and pass cleared on the same edge.
- Latency: done rises 2 edges after the edge that samples the final valid response (RUN→CHECK, then CHECK→DONE).
- start and resp_valid on the same edge in IDLE or DONE: only start acts. The response is not compacted; compaction begins on the following edge.
- PATTERN_COUNT never exceeds N_PATTERNS; there is no wrap within a run.
- busy = (state==RUN || state==CHECK), registered with the state.

Test Plan (all scenarios: IN_BITS=4, SIG_BITS=8, POLY=8'h1D, CNT_BITS=4):
- Reset: rst=0 for 2 edges with start and resp_valid toggling → SIGNATURE=SEED, PATTERN_COUNT=0, busy=0, done=0, pass=0.
- Basic compaction, pass (SEED=0, N=3): start, then RESP=1,2,3 with resp_valid=1, GOLDEN=8'h03 → SIGNATURE 01, 00, 03; done=1 two edges after the last response; pass=1; PATTERN_COUNT=3.
- Feedback tap and fail (SEED=8'h80, N=1): start, RESP=0 valid, GOLDEN=8'h00 → SIGNATURE=8'h1D; done=1; pass=0.
- Stall and ignored inputs (SEED=0, N=3):
  - Stimulus: RESP=1,2,3 with resp_valid=0 gaps of 2 cycles between responses; extra start pulse mid-run.
  - Response: same signature 8'h03 and pass=1; start had no effect; busy stays high through the gaps.
- Restart from DONE and reset mid-run:
  - Start in DONE → done and pass clear; a new run with RESP=5 (N=1, SEED=0) gives 8'h05.
  - rst=0 asserted after 1 of 3 responses → all outputs return to reset values next edge; no done follows.

Source files
------------

// File: rtl/lbist_ora.sv
// rtl/lbist_ora.sv - LBIST output response analyzer: MISR compaction, pattern count, golden compare
module lbist_ora #(
    parameter int                  IN_BITS    = 4,
    parameter int                  SIG_BITS   = 16,
    parameter logic [SIG_BITS-1:0] POLY       = 16'h002D,
    parameter logic [SIG_BITS-1:0] SEED       = '0,
    parameter int                  N_PATTERNS = 15,
    parameter int                  CNT_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                resp_valid,
    input  logic [IN_BITS-1:0]  RESP,
    input  logic [SIG_BITS-1:0] GOLDEN,
    output logic [SIG_BITS-1:0] SIGNATURE,
    output logic [CNT_BITS-1:0] PATTERN_COUNT,
    output logic                busy,
    output logic                done,
    output logic                pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(N_PATTERNS - 1);

    state_t              state;
    state_t              state_nx;
    logic [SIG_BITS-1:0] resp_ext;
    logic [SIG_BITS-1:0] misr_nx;

    assign resp_ext = SIG_BITS'(RESP);
    assign misr_nx  = {SIGNATURE[SIG_BITS-2:0], 1'b0}
                    ^ (SIGNATURE[SIG_BITS-1] ? POLY : '0)
                    ^ resp_ext;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (resp_valid && PATTERN_COUNT == LAST_CNT) state_nx = S_CHECK;
            S_CHECK: state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            SIGNATURE     <= SEED;
            PATTERN_COUNT <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == S_RUN) || (state_nx == S_CHECK);
            done  <= (state_nx == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        SIGNATURE     <= SEED;
                        PATTERN_COUNT <= '0;
                        pass          <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (resp_valid) begin
                        SIGNATURE     <= misr_nx;
                        PATTERN_COUNT <= PATTERN_COUNT + 1'b1;
                    end
                end
                S_CHECK: pass <= (SIGNATURE == GOLDEN);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbist_ora.sv
// tb/tb_lbist_ora.sv - directed bench for lbist_ora with a signature scoreboard
module tb_lbist_ora;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, valid_a, start_b, valid_b;
    logic [3:0] resp_a, resp_b;
    logic [7:0] golden_a, golden_b;
    logic [7:0] sig_a, sig_b;
    logic [3:0] cnt_a, cnt_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_a;

    always #5 clk = ~clk;

    lbist_ora #(
        .IN_BITS(4), .SIG_BITS(8), .POLY(8'h1D), .SEED(8'h00), .N_PATTERNS(3), .CNT_BITS(4)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .resp_valid(valid_a), .RESP(resp_a),
        .GOLDEN(golden_a), .SIGNATURE(sig_a), .PATTERN_COUNT(cnt_a),
        .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    lbist_ora #(
        .IN_BITS(4), .SIG_BITS(8), .POLY(8'h1D), .SEED(8'h80), .N_PATTERNS(1), .CNT_BITS(4)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .resp_valid(valid_b), .RESP(resp_b),
        .GOLDEN(golden_b), .SIGNATURE(sig_b), .PATTERN_COUNT(cnt_b),
        .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    function automatic logic [7:0] misr(input logic [7:0] s, input logic [3:0] r);
        logic [7:0] n;
        n = {s[6:0], 1'b0};
        if (s[7]) n = n ^ 8'h1D;
        return n ^ {4'h0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status_a(input string tag, input logic b, input logic d, input logic p);
        chk({tag, "_busy"}, 32'(busy_a), 32'(b));
        chk({tag, "_done"}, 32'(done_a), 32'(d));
        chk({tag, "_pass"}, 32'(pass_a), 32'(p));
    endtask

    task automatic start_run_a(input logic also_valid);
        start_a = 1'b1;
        valid_a = also_valid;
        resp_a  = 4'hF;
        tick();
        start_a = 1'b0;
        valid_a = 1'b0;
        model_a = 8'h00;
        chk("start_sig", 32'(sig_a), 32'h00);
        chk("start_cnt", 32'(cnt_a), 32'h0);
        chk("start_busy", 32'(busy_a), 32'h1);
    endtask

    task automatic send_a(input logic [3:0] r, input logic [3:0] exp_cnt);
        resp_a  = r;
        valid_a = 1'b1;
        model_a = misr(model_a, r);
        exp_q.push_back(model_a);
        tick();
        valid_a = 1'b0;
        chk("sig_a", 32'(sig_a), 32'(exp_q.pop_front()));
        chk("cnt_a", 32'(cnt_a), 32'(exp_cnt));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start_a = 1'b0; valid_a = 1'b0; resp_a = 4'h0; golden_a = 8'h03;
        start_b = 1'b0; valid_b = 1'b0; resp_b = 4'h0; golden_b = 8'h00;
        model_a = 8'h00;

        // Reset with toggling start/resp_valid
        for (int i = 0; i < 2; i++) begin
            start_a = i[0]; valid_a = ~i[0]; start_b = ~i[0]; valid_b = i[0];
            tick();
        end
        chk("rst_sig_a", 32'(sig_a), 32'h00);
        chk("rst_cnt_a", 32'(cnt_a), 32'h0);
        chk_status_a("rst_a", 1'b0, 1'b0, 1'b0);
        chk("rst_sig_b", 32'(sig_b), 32'h80);
        chk("rst_busy_b", 32'(busy_b), 32'h0);
        start_a = 0; valid_a = 0; start_b = 0; valid_b = 0;
        rst = 1'b1;
        tick();
        chk_status_a("idle_a", 1'b0, 1'b0, 1'b0);

        // Basic compaction, pass
        start_run_a(1'b0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        for (int i = 1; i <= 3; i++) begin
            resp_a = 4'(i); valid_a = 1'b1;
            model_a = misr(model_a, 4'(i));
            tick();
            valid_a = 1'b0;
            chk("basic_sig", 32'(sig_a), 32'(exp_q.pop_front()));
            chk("basic_model", 32'(sig_a), 32'(model_a));
        end
        chk_status_a("check_a", 1'b1, 1'b0, 1'b0);
        tick();
        chk_status_a("done_a", 1'b0, 1'b1, 1'b1);
        chk("done_cnt_a", 32'(cnt_a), 32'h3);
        resp_a = 4'hF; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        chk("done_frozen_sig", 32'(sig_a), 32'h03);
        chk("done_frozen_cnt", 32'(cnt_a), 32'h3);
        chk_status_a("done_hold", 1'b0, 1'b1, 1'b1);

        // Feedback tap and fail on dut_b
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start_sig", 32'(sig_b), 32'h80);
        resp_b = 4'h0; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        chk("b_sig", 32'(sig_b), 32'h1D);
        chk("b_cnt", 32'(cnt_b), 32'h1);
        tick();
        chk("b_done", 32'(done_b), 32'h1);
        chk("b_pass", 32'(pass_b), 32'h0);

        // Stall and ignored inputs; start+valid together in DONE only restarts
        start_run_a(1'b1);
        chk("restart_done_clr", 32'(done_a), 32'h0);
        chk("restart_pass_clr", 32'(pass_a), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            send_a(4'(i), 4'(i));
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    resp_a = 4'hA;
                    start_a = (i == 1 && g == 0);
                    tick();
                    start_a = 1'b0;
                    chk("stall_sig", 32'(sig_a), 32'(model_a));
                    chk("stall_cnt", 32'(cnt_a), 32'(i));
                    chk("stall_busy", 32'(busy_a), 32'h1);
                end
            end
        end
        tick();
        chk_status_a("stall_done", 1'b0, 1'b1, 1'b1);
        chk("stall_final_sig", 32'(sig_a), 32'h03);

        // Restart from DONE with a failing golden value
        golden_a = 8'h00;
        start_run_a(1'b0);
        send_a(4'h5, 4'h1);
        chk("rs_first_sig", 32'(sig_a), 32'h05);
        send_a(4'h0, 4'h2);
        send_a(4'h0, 4'h3);
        tick();
        chk_status_a("rs_done", 1'b0, 1'b1, 1'b0);
        chk("rs_sig", 32'(sig_a), 32'h14);

        // Reset mid-run
        start_run_a(1'b0);
        send_a(4'h1, 4'h1);
        rst = 1'b0; start_a = 1'b1; valid_a = 1'b1;
        tick();
        rst = 1'b1; start_a = 1'b0; valid_a = 1'b0;
        chk("mid_rst_sig", 32'(sig_a), 32'h00);
        chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
        chk_status_a("mid_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_done", 32'(done_a), 32'h0);
            chk("post_rst_busy", 32'(busy_a), 32'h0);
        end
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
